// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage: PC, single-outstanding imem fetch, output register with hold buffer
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel (word aligned address)
//   imem_resp_valid/data             fetch response, at least one cycle after acceptance
//   redirect_valid/pc                PC redirect from branch resolution, highest priority
//   inst_valid/ready, inst, inst_pc  output register towards decode
//   opcode                           inst[6:0], always driven from the output register
module instruction_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);

    typedef enum logic [2:0] {
        S_RST,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(4);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] hold_data;
    logic [XLEN-1:0] hold_pc;
    logic            hold_valid;

    // Request channel is a pure decode of registered state, so nothing on the
    // input side can reach it combinationally.
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign opcode         = inst[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RST;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            hold_data  <= '0;
            hold_pc    <= '0;
            hold_valid <= 1'b0;
        end else begin
            // Consumption without a new load empties the output register;
            // a load further down overrides this.
            if (inst_valid && inst_ready) begin
                inst_valid <= 1'b0;
            end

            if (state != S_RST && redirect_valid) begin
                pc         <= redirect_pc & ALIGN_MASK;
                inst_valid <= 1'b0;
                hold_valid <= 1'b0;
                // Any fetch still in flight after this edge must be drained
                // so its data never reaches the output register.
                case (state)
                    S_REQ:   state <= imem_req_ready  ? S_DRAIN : S_REQ;
                    S_WAIT:  state <= imem_resp_valid ? S_REQ   : S_DRAIN;
                    S_DRAIN: state <= imem_resp_valid ? S_REQ   : S_DRAIN;
                    default: state <= S_REQ;
                endcase
            end else begin
                case (state)
                    S_RST: begin
                        state <= S_REQ;
                    end
                    S_REQ: begin
                        if (imem_req_ready) begin
                            req_pc <= pc;
                            pc     <= pc + WORD_STEP;
                            state  <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_resp_valid) begin
                            if (!inst_valid || inst_ready) begin
                                inst       <= imem_resp_data;
                                inst_pc    <= req_pc;
                                inst_valid <= 1'b1;
                                state      <= S_REQ;
                            end else begin
                                hold_data  <= imem_resp_data;
                                hold_pc    <= req_pc;
                                hold_valid <= 1'b1;
                                state      <= S_HOLD;
                            end
                        end
                    end
                    S_HOLD: begin
                        // No new fetch is issued until the buffered word moves out.
                        if (inst_ready && hold_valid) begin
                            inst       <= hold_data;
                            inst_pc    <= hold_pc;
                            inst_valid <= 1'b1;
                            hold_valid <= 1'b0;
                            state      <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_resp_valid) begin
                            state <= S_REQ;
                        end
                    end
                    default: begin
                        state <= S_RST;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: RESET_PC = 0
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data  = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;

    // DUT 2: RESET_PC = 0xFFFF_FFFC
    logic        rst_n2;
    logic        req_valid2;
    logic        req_ready2;
    logic [31:0] req_addr2;
    logic        resp_valid2 = 1'b0;
    logic [31:0] resp_data2  = '0;
    logic        redirect_valid2;
    logic [31:0] redirect_pc2;
    logic        inst_valid2;
    logic        inst_ready2;
    logic [31:0] inst2;
    logic [31:0] inst_pc2;
    logic [6:0]  opcode2;

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .opcode(opcode)
    );

    instruction_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n2),
        .imem_req_valid(req_valid2), .imem_req_ready(req_ready2), .imem_req_addr(req_addr2),
        .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst(inst2),
        .inst_pc(inst_pc2), .opcode(opcode2)
    );

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    int          exp_rd = 0;
    logic [31:0] req_log[$];
    logic [31:0] req2_log[$];
    logic [31:0] dl2_pc[$];
    logic [31:0] dl2_inst[$];
    logic [31:0] mon_w;
    int          mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    // Memory model for DUT 1 with programmable response latency (>= 1)
    logic        pend  = 1'b0;
    int          cnt   = 0;
    logic [31:0] paddr = '0;
    always @(posedge clk) begin
        resp_valid <= 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_word(paddr);
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (req_valid && req_ready) begin
            if (mem_lat <= 1) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_word(req_addr);
            end else begin
                pend  <= 1'b1;
                cnt   <= mem_lat - 2;
                paddr <= req_addr;
            end
        end
    end

    // Memory model for DUT 2: always ready, one-cycle response
    always @(posedge clk) begin
        resp_valid2 <= req_valid2 && req_ready2;
        resp_data2  <= mem_word(req_addr2);
    end

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        req_ready      = 1'b1;
        mem_lat        = 1;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        inst_ready     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
        tests++; if (req_addr !== 32'h0) begin fails++; $display("FAIL reset_req_addr: got %h expected 00000000", req_addr); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
        tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 00000000", inst); end
        tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc: got %h expected 00000000", inst_pc); end
        tests++; if (opcode !== 7'h0) begin fails++; $display("FAIL reset_opcode: got %h expected 00", opcode); end
    endtask

    task automatic test_stream();
        int base;
        int req_cyc[$];
        int val_cyc;
        apply_reset();
        inst_ready = 1'b1;
        base    = req_log.size();
        val_cyc = -1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 40 && exp_rd < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            if (req_valid && req_ready) req_cyc.push_back(i);
            if (inst_valid && val_cyc < 0) val_cyc = i;
        end
        inst_ready = 1'b0;
        tests++; if (exp_rd != exp_q.size()) begin fails++; $display("FAIL stream_timeout: delivered %0d expected %0d", exp_rd, exp_q.size()); end
        tests++;
        if (req_log.size() < base + 3) begin
            fails++; $display("FAIL stream_req_count: got %0d expected >=3", req_log.size() - base);
        end else if (req_log[base] !== 32'h0 || req_log[base+1] !== 32'h4 || req_log[base+2] !== 32'h8) begin
            fails++; $display("FAIL stream_req_addr: got %h %h %h expected 0 4 8", req_log[base], req_log[base+1], req_log[base+2]);
        end
        tests++;
        if (req_cyc.size() < 3) begin
            fails++; $display("FAIL stream_req_cycles: got %0d requests expected >=3", req_cyc.size());
        end else begin
            if (val_cyc - req_cyc[0] != 2) begin fails++; $display("FAIL stream_latency: got %0d expected 2", val_cyc - req_cyc[0]); end
            tests++;
            if (req_cyc[1] - req_cyc[0] != 2 || req_cyc[2] - req_cyc[1] != 2) begin
                fails++; $display("FAIL stream_throughput: got %0d %0d expected 2 2", req_cyc[1] - req_cyc[0], req_cyc[2] - req_cyc[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base;
        apply_reset();
        base = req_log.size();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 20 && !inst_valid; i++) begin
            @(posedge clk);
            #1;
        end
        tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b expected 1", inst_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
                fails++; $display("FAIL bp_stable: got v=%b pc=%h inst=%h expected v=1 pc=0 inst=%h", inst_valid, inst_pc, inst, mem_word(32'h0));
            end
        end
        tests++; if (req_log.size() - base != 2) begin fails++; $display("FAIL bp_no_third_req: got %0d requests expected 2", req_log.size() - base); end
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL bp_hold_no_req: got %b expected 0", req_valid); end
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && exp_rd < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        tests++; if (exp_rd != exp_q.size()) begin fails++; $display("FAIL bp_drain: delivered %0d expected %0d", exp_rd, exp_q.size()); end
    endtask

    task automatic test_redirect_drain();
        int base;
        bit found;
        apply_reset();
        inst_ready = 1'b1;
        base  = req_log.size();
        found = 1'b0;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            if (req_valid && req_addr == 32'h8) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rd_find_req8: got none expected request to 00000008"); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rd_drain_no_req: got %b expected 0", req_valid); end
        for (int i = 0; i < 40 && exp_rd < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        tests++; if (exp_rd != exp_q.size()) begin fails++; $display("FAIL rd_timeout: delivered %0d expected %0d", exp_rd, exp_q.size()); end
        tests++;
        if (req_log.size() < base + 4) begin
            fails++; $display("FAIL rd_req_count: got %0d expected >=4", req_log.size() - base);
        end else if (req_log[base+3] !== 32'h100) begin
            fails++; $display("FAIL rd_next_req: got %h expected 00000100", req_log[base+3]);
        end
    endtask

    task automatic test_redirect_wait_resp();
        bit found;
        apply_reset();
        inst_ready = 1'b1;
        found = 1'b0;
        exp_q.push_back(32'h0);
        for (int i = 0; i < 30 && !found; i++) begin
            @(posedge clk);
            #1;
            if (req_valid && req_addr == 32'h4) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rw_find_req4: got none expected request to 00000004"); end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        exp_q.push_back(32'h200);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        tests++; if (req_valid !== 1'b1) begin fails++; $display("FAIL rw_req_valid: got %b expected 1", req_valid); end
        tests++; if (req_addr !== 32'h200) begin fails++; $display("FAIL rw_req_addr: got %h expected 00000200", req_addr); end
        for (int i = 0; i < 30 && exp_rd < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
        end
        inst_ready = 1'b0;
        tests++; if (exp_rd != exp_q.size()) begin fails++; $display("FAIL rw_timeout: delivered %0d expected %0d", exp_rd, exp_q.size()); end
    endtask

    task automatic test_reset_mid_fetch();
        bit found;
        bit seen;
        apply_reset();
        mem_lat = 4;
        found = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (req_valid && req_ready) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL rm_find_req: got none expected a request"); end
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_ready = 1'b0;
        #1;
        tests++; if (req_valid !== 1'b0) begin fails++; $display("FAIL rm_req_valid: got %b expected 0", req_valid); end
        tests++; if (req_addr !== 32'h0) begin fails++; $display("FAIL rm_req_addr: got %h expected 00000000", req_addr); end
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rm_inst_valid: got %b expected 0", inst_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (inst_valid) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rm_late_resp: got instruction pc=%h expected none", inst_pc); end
        req_ready = 1'b1;
    endtask

    task automatic test_reset_pc_wrap();
        tests++; if (req_addr2 !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_reset_addr: got %h expected fffffffc", req_addr2); end
        rst_n2 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (req2_log.size() < 2) begin
            fails++; $display("FAIL wrap_req_count: got %0d expected >=2", req2_log.size());
        end else if (req2_log[0] !== 32'hFFFF_FFFC || req2_log[1] !== 32'h0) begin
            fails++; $display("FAIL wrap_req_addr: got %h %h expected fffffffc 00000000", req2_log[0], req2_log[1]);
        end
        tests++;
        if (dl2_pc.size() < 2) begin
            fails++; $display("FAIL wrap_deliver_count: got %0d expected >=2", dl2_pc.size());
        end else if (dl2_pc[0] !== 32'hFFFF_FFFC || dl2_pc[1] !== 32'h0 || dl2_inst[0] !== mem_word(32'hFFFF_FFFC)) begin
            fails++; $display("FAIL wrap_deliver: got pc %h %h inst %h expected fffffffc 00000000 %h", dl2_pc[0], dl2_pc[1], dl2_inst[0], mem_word(32'hFFFF_FFFC));
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        req_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
        rst_n2          = 1'b0;
        req_ready2      = 1'b1;
        redirect_valid2 = 1'b0;
        redirect_pc2    = '0;
        inst_ready2     = 1'b1;

        // Monitor: logs requests and scores every delivered instruction
        // against the expected queue, sampled away from the active edge.
        fork
            forever begin
                @(negedge clk);
                if (req_valid && req_ready) req_log.push_back(req_addr);
                if (req_valid2 && req_ready2) req2_log.push_back(req_addr2);
                if (inst_valid2 && inst_ready2) begin
                    dl2_pc.push_back(inst_pc2);
                    dl2_inst.push_back(inst2);
                end
                if (rst_n && inst_valid && inst_ready) begin
                    tests++;
                    if (exp_rd >= exp_q.size()) begin
                        fails++;
                        $display("FAIL deliver_unexpected: got pc=%h inst=%h expected no instruction", inst_pc, inst);
                    end else begin
                        mon_w = mem_word(exp_q[exp_rd]);
                        if (inst_pc !== exp_q[exp_rd] || inst !== mon_w || opcode !== mon_w[6:0]) begin
                            fails++;
                            $display("FAIL deliver: got pc=%h inst=%h op=%h expected pc=%h inst=%h op=%h",
                                     inst_pc, inst, opcode, exp_q[exp_rd], mon_w, mon_w[6:0]);
                        end
                        exp_rd++;
                    end
                end
            end
        join_none

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_wait_resp();
        test_reset_mid_fetch();
        test_reset_pc_wrap();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
